cond_exec_unit: RTL and testbench
=================================

COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

Interface
REQ-001 Parameter NUM_CTX, default 2: number of independent flag contexts (1..8).
REQ-002 Parameter BLK_MAX, default 4: maximum predicated-block length in instructions (1..15).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 valid_i  in  1  instruction present this cycle.
REQ-006 cond_i  in  4  instruction condition code (ARM encoding).
REQ-007 ctx_i  in  max(1,$clog2(NUM_CTX))  flag context selected by instruction.
REQ-008 alu_flags_i  in  4  new flags {N,Z,C,V}, bit3 = N, bit0 = V.
REQ-009 flag_wr_i  in  2  bit1 = write N,Z; bit0 = write C,V.
REQ-010 reg_wr_i, mem_wr_i, pc_src_i  in  1 each  ungated control requests.
REQ-011 blk_start_i  in  1  instruction is a block prefix opening a predicated block.
REQ-012 blk_len_i  in  4  requested block length.
REQ-013 reg_wr_o, mem_wr_o, pc_src_o  out  1 each  gated controls.
REQ-014 condex_o  out  1  effective condition passed.
REQ-015 flags_o  out  4  stored flags of context ctx_i, pre-update.
REQ-016 blk_active_o  out  1  predicated block open; blk_left_o  out  4  instructions remaining.

Function
REQ-017 Condition evaluation SHALL be combinational on stored flags: 0000 Z, 0001 !Z, 0010 C, 0011 !C, 0100 N, 0101 !N, 0110 V, 0111 !V, 1000 C&!Z, 1001 !(C&!Z), 1010 N==V, 1011 N!=V, 1100 !Z&(N==V), 1101 !(!Z&(N==V)), 1110 1, 1111 0 (never X).
REQ-018 Effective cond/ctx SHALL be cond_i/ctx_i in IDLE and the latched block cond/ctx in BLOCK.
REQ-019 condex_o SHALL equal valid_i AND evaluated effective condition; zero latency.
REQ-020 Each gated output SHALL equal its request AND condex_o; prefix instructions SHALL drive all gated outputs 0.
REQ-021 On clock edge with condex_o=1 and non-prefix, flag_wr_i[1] SHALL load N,Z and flag_wr_i[0] SHALL load C,V of the effective context; other contexts unchanged.
REQ-022 FSM IDLE->BLOCK on valid_i & blk_start_i & blk_len_i!=0: latch cond_i, ctx_i, count=min(blk_len_i,BLK_MAX); prefix evaluates nothing, writes no flags.
REQ-023 blk_start_i with blk_len_i=0 SHALL be a no-op prefix; FSM stays IDLE.
REQ-024 In BLOCK each valid_i cycle SHALL decrement count; count 1->0 SHALL return to IDLE the next cycle; invalid cycles hold count.
REQ-025 blk_start_i in BLOCK SHALL be ignored as prefix (treated as ordinary block instruction).
REQ-026 Flag writes inside a block SHALL affect evaluation of later block instructions (flags re-read each cycle).
REQ-027 blk_left_o SHALL show count, 0 in IDLE; blk_active_o=1 exactly in BLOCK.

Reset
REQ-028 rst SHALL clear all contexts' flags to 0000, FSM to IDLE, count and latched cond/ctx to 0, including mid-block; rst dominates all other inputs.

Configuration
REQ-029 Macro COND_BLOCK_EN: defined -> REQ-022..027 active; undefined -> no FSM, blk_start_i/blk_len_i ignored (instruction evaluated normally), blk_active_o=0, blk_left_o=0.

Structure
REQ-030 Package cond_exec_pkg SHALL hold cond_e enum (EQ..AL,NV), flags_t packed struct {n,z,c,v}, blk_state_e {IDLE,BLOCK}.
REQ-031 Sub-module cond_eval SHALL implement REQ-017 combinationally (cond, flags_t -> pass).

Verification
REQ-032 After rst, cond=0000 ctx0 valid -> condex_o=0 (Z=0); cond=1110 reg_wr_i=1 -> reg_wr_o=1; cond=1111 -> condex_o=0.
REQ-033 ctx0 flag_wr=10 alu_flags=0100, ctx1 untouched; next cycle cond=0000 ctx0 -> condex 1, ctx1 -> condex 0.
REQ-034 Prefix cond=0001 len=3 with Z=1 -> blk_left 3,2,1 over three valid instructions, all gated outputs 0, IDLE after third.
REQ-035 Prefix len=9 with BLK_MAX=4 -> blk_left_o=4; rst asserted after 2 instructions -> IDLE, blk_left 0, flags 0000.
REQ-036 Block cond=0000, first instruction clears Z (flag_wr=10, flags 0000) -> second instruction condex 0.
REQ-037 COND_BLOCK_EN undefined: blk_start_i=1 cond=1110 reg_wr_i=1 -> reg_wr_o=1, blk_active_o=0.

Source files
------------

// File: rtl/cond_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cond_exec_pkg
// Description : Shared types for the conditional-execution unit: ARM-style
//               condition codes, the packed flag word and block FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package cond_exec_pkg;

    // ARM condition-code encoding; NV (1111) always fails here.
    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    // Stored flags, packed so that bit3 = N and bit0 = V.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Predicated-block sequencer states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BLOCK = 1'b1
    } blk_state_e;

endpackage : cond_exec_pkg
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Purely combinational condition-code evaluator. Maps a
//               condition code and a flag word to a single pass bit.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import cond_exec_pkg::*;
(
    input  cond_e  cond_i,
    input  flags_t flags_i,
    output logic   pass_o
);

    // Decode the condition against the supplied flags; default keeps the
    // output a known 0 for any unexpected encoding.
    always_comb begin
        pass_o = 1'b0;
        unique case (cond_i)
            EQ: pass_o =  flags_i.z;
            NE: pass_o = ~flags_i.z;
            CS: pass_o =  flags_i.c;
            CC: pass_o = ~flags_i.c;
            MI: pass_o =  flags_i.n;
            PL: pass_o = ~flags_i.n;
            VS: pass_o =  flags_i.v;
            VC: pass_o = ~flags_i.v;
            HI: pass_o =  (flags_i.c & ~flags_i.z);
            LS: pass_o = ~(flags_i.c & ~flags_i.z);
            GE: pass_o =  (flags_i.n == flags_i.v);
            LT: pass_o =  (flags_i.n != flags_i.v);
            GT: pass_o =  (~flags_i.z & (flags_i.n == flags_i.v));
            LE: pass_o = ~(~flags_i.z & (flags_i.n == flags_i.v));
            AL: pass_o = 1'b1;
            NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule : cond_eval
`default_nettype wire

// File: rtl/cond_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : cond_exec_unit
// Description : Conditional-execution unit with NUM_CTX independent flag
//               contexts. Gates register/memory/PC controls on the
//               evaluated condition and updates flags of the effective
//               context. Optional predicated-block sequencer is compiled in
//               when the macro COND_BLOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_exec_unit
    import cond_exec_pkg::*;
#(
    parameter  int NUM_CTX = 2,
    parameter  int BLK_MAX = 4,
    localparam int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [3:0]       cond_i,
    input  logic [CTX_W-1:0] ctx_i,
    input  logic [3:0]       alu_flags_i,
    input  logic [1:0]       flag_wr_i,
    input  logic             reg_wr_i,
    input  logic             mem_wr_i,
    input  logic             pc_src_i,
    input  logic             blk_start_i,
    input  logic [3:0]       blk_len_i,
    output logic             reg_wr_o,
    output logic             mem_wr_o,
    output logic             pc_src_o,
    output logic             condex_o,
    output logic [3:0]       flags_o,
    output logic             blk_active_o,
    output logic [3:0]       blk_left_o
);

    flags_t           flags_q [NUM_CTX];

    cond_e            w_eff_cond;
    logic [CTX_W-1:0] w_eff_ctx;
    flags_t           w_eff_flags;
    flags_t           w_sel_flags;
    logic             w_pass;
    logic             w_prefix;
    logic             w_condex;

`ifdef COND_BLOCK_EN
    localparam logic [3:0] C_BLK_MAX = 4'(BLK_MAX);

    blk_state_e       state_q, state_d;
    logic [3:0]       count_q, count_d;
    cond_e            bcond_q, bcond_d;
    logic [CTX_W-1:0] bctx_q,  bctx_d;
    logic [3:0]       w_len_clip;

    assign w_len_clip = (blk_len_i > C_BLK_MAX) ? C_BLK_MAX : blk_len_i;

    // A block-start request only acts as a prefix while no block is open.
    assign w_prefix   = (state_q == IDLE) & blk_start_i;
    assign w_eff_cond = (state_q == BLOCK) ? bcond_q : cond_e'(cond_i);
    assign w_eff_ctx  = (state_q == BLOCK) ? bctx_q  : ctx_i;

    // Block sequencer state, remaining count and latched condition/context.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            bcond_q <= EQ;
            bctx_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bcond_q <= bcond_d;
            bctx_q  <= bctx_d;
        end
    end

    // Open a block on a non-empty prefix; count down on each valid
    // instruction inside it and close once the last one has issued.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        bcond_d = bcond_q;
        bctx_d  = bctx_q;
        unique case (state_q)
            IDLE: begin
                if (valid_i && blk_start_i && (blk_len_i != 4'd0)) begin
                    state_d = BLOCK;
                    count_d = w_len_clip;
                    bcond_d = cond_e'(cond_i);
                    bctx_d  = ctx_i;
                end
            end
            BLOCK: begin
                if (valid_i) begin
                    count_d = count_q - 4'd1;
                    if (count_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign blk_active_o = (state_q == BLOCK);
    assign blk_left_o   = count_q;
`else
    logic unused_blk_inputs;

    // Without block support every instruction is evaluated on its own.
    assign unused_blk_inputs = ^{blk_start_i, blk_len_i};
    assign w_prefix          = 1'b0;
    assign w_eff_cond        = cond_e'(cond_i);
    assign w_eff_ctx         = ctx_i;
    assign blk_active_o      = 1'b0;
    assign blk_left_o        = 4'd0;
`endif

    // Select flags for the effective context (evaluation) and for ctx_i
    // (observation); out-of-range contexts read as all-zero.
    always_comb begin
        w_eff_flags = '0;
        w_sel_flags = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (w_eff_ctx == CTX_W'(i)) begin
                w_eff_flags = flags_q[i];
            end
            if (ctx_i == CTX_W'(i)) begin
                w_sel_flags = flags_q[i];
            end
        end
    end

    cond_eval u_cond_eval (
        .cond_i  (w_eff_cond),
        .flags_i (w_eff_flags),
        .pass_o  (w_pass)
    );

    assign w_condex = valid_i & w_pass & ~w_prefix;

    assign condex_o = w_condex;
    assign reg_wr_o = reg_wr_i & w_condex;
    assign mem_wr_o = mem_wr_i & w_condex;
    assign pc_src_o = pc_src_i & w_condex;
    assign flags_o  = w_sel_flags;

    // Flag storage: only the effective context of a passing instruction is
    // written, N/Z and C/V pairs independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                flags_q[i] <= '0;
            end
        end else if (w_condex) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                if (w_eff_ctx == CTX_W'(i)) begin
                    if (flag_wr_i[1]) begin
                        flags_q[i].n <= alu_flags_i[3];
                        flags_q[i].z <= alu_flags_i[2];
                    end
                    if (flag_wr_i[0]) begin
                        flags_q[i].c <= alu_flags_i[1];
                        flags_q[i].v <= alu_flags_i[0];
                    end
                end
            end
        end
    end

endmodule : cond_exec_unit
`default_nettype wire

// File: tb/tb_cond_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_exec_unit
// Description : Self-checking bench for cond_exec_unit: directed literal
//               cases plus randomized traffic against a behavioural model.
//               Block-mode cases are compiled when COND_BLOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_exec_unit;

    localparam int NUM_CTX = 2;
    localparam int BLK_MAX = 4;
    localparam int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
`ifdef COND_BLOCK_EN
    localparam bit BLK_EN = 1'b1;
`else
    localparam bit BLK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_i = 1'b0;
    logic [3:0]       cond_i = '0;
    logic [CTX_W-1:0] ctx_i = '0;
    logic [3:0]       alu_flags_i = '0;
    logic [1:0]       flag_wr_i = '0;
    logic             reg_wr_i = 1'b0;
    logic             mem_wr_i = 1'b0;
    logic             pc_src_i = 1'b0;
    logic             blk_start_i = 1'b0;
    logic [3:0]       blk_len_i = '0;
    logic             reg_wr_o, mem_wr_o, pc_src_o, condex_o, blk_active_o;
    logic [3:0]       flags_o, blk_left_o;

    cond_exec_unit #(.NUM_CTX(NUM_CTX), .BLK_MAX(BLK_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .cond_i       (cond_i),
        .ctx_i        (ctx_i),
        .alu_flags_i  (alu_flags_i),
        .flag_wr_i    (flag_wr_i),
        .reg_wr_i     (reg_wr_i),
        .mem_wr_i     (mem_wr_i),
        .pc_src_i     (pc_src_i),
        .blk_start_i  (blk_start_i),
        .blk_len_i    (blk_len_i),
        .reg_wr_o     (reg_wr_o),
        .mem_wr_o     (mem_wr_o),
        .pc_src_o     (pc_src_o),
        .condex_o     (condex_o),
        .flags_o      (flags_o),
        .blk_active_o (blk_active_o),
        .blk_left_o   (blk_left_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] m_flags [NUM_CTX];
    bit         m_blk  = 1'b0;
    int         m_left = 0;
    logic [3:0] m_cond = '0;
    int         m_ctx  = 0;

    initial for (int i = 0; i < NUM_CTX; i++) m_flags[i] = '0;

    // Conditions come in pairs: odd code = inverse of the even code below it.
    function automatic bit eval_ref(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic bit m_is_prefix();
        return BLK_EN && !m_blk && blk_start_i;
    endfunction

    function automatic bit m_condex();
        logic [3:0] ec;
        int ex;
        ec = m_blk ? m_cond : cond_i;
        ex = m_blk ? m_ctx : int'(ctx_i);
        return valid_i && !m_is_prefix() && eval_ref(ec, m_flags[ex]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CTX; i++) m_flags[i] = '0;
            m_blk = 1'b0; m_left = 0; m_cond = '0; m_ctx = 0;
        end else begin
            bit cx, pf;
            int ex;
            cx = m_condex();
            pf = m_is_prefix();
            ex = m_blk ? m_ctx : int'(ctx_i);
            if (cx) begin
                if (flag_wr_i[1]) m_flags[ex][3:2] = alu_flags_i[3:2];
                if (flag_wr_i[0]) m_flags[ex][1:0] = alu_flags_i[1:0];
            end
            if (m_blk) begin
                if (valid_i) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_blk = 1'b0;
                end
            end else if (pf && valid_i && blk_len_i != 0) begin
                m_blk  = 1'b1;
                m_left = (int'(blk_len_i) > BLK_MAX) ? BLK_MAX : int'(blk_len_i);
                m_cond = cond_i;
                m_ctx  = int'(ctx_i);
            end
        end
    end

    // Compare process: mid-cycle, outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit cx;
            cx = m_condex();
            chk("condex", int'(condex_o), int'(cx));
            chk("reg_wr", int'(reg_wr_o), int'(reg_wr_i && cx));
            chk("mem_wr", int'(mem_wr_o), int'(mem_wr_i && cx));
            chk("pc_src", int'(pc_src_o), int'(pc_src_i && cx));
            chk("flags",  int'(flags_o), int'(m_flags[int'(ctx_i)]));
            chk("blk_active", int'(blk_active_o), int'(m_blk));
            chk("blk_left", int'(blk_left_o), m_left);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [3:0] c, input int cx,
                         input logic [3:0] al, input logic [1:0] fw,
                         input bit rw, input bit mw, input bit pc,
                         input bit bs, input logic [3:0] bl);
        valid_i = v; cond_i = c; ctx_i = CTX_W'(cx);
        alu_flags_i = al; flag_wr_i = fw;
        reg_wr_i = rw; mem_wr_i = mw; pc_src_i = pc;
        blk_start_i = bs; blk_len_i = bl;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 4'h0, 0, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0);
        tick();
        tick();
        chk_en = 1'b1;
        #3;
        chk("rst_flags", int'(flags_o), 0);
        chk("rst_left", int'(blk_left_o), 0);
        chk("rst_active", int'(blk_active_o), 0);
        tick();
        rst = 1'b0;

        // EQ with Z=0 fails; AL passes; NV fails.
        drive(1, 4'b0000, 0, 4'h0, 2'b00, 1, 0, 0, 0, 4'h0);
        #3 chk("eq_after_rst", int'(condex_o), 0);
        tick();
        drive(1, 4'b1110, 0, 4'h0, 2'b00, 1, 0, 0, 0, 4'h0);
        #3 chk("al_reg_wr", int'(reg_wr_o), 1);
        tick();
        drive(1, 4'b1111, 0, 4'h0, 2'b00, 1, 1, 1, 0, 4'h0);
        #3 chk("nv_condex", int'(condex_o), 0);
        chk("nv_reg_wr", int'(reg_wr_o), 0);
        tick();

        // Set Z in ctx0 only.
        drive(1, 4'b1110, 0, 4'b0100, 2'b10, 0, 0, 0, 0, 4'h0);
        #3 chk("al_write", int'(condex_o), 1);
        tick();
        drive(1, 4'b0000, 0, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0);
        #3 chk("eq_ctx0", int'(condex_o), 1);
        chk("flags_ctx0", int'(flags_o), 4);
        tick();
        drive(1, 4'b0000, 1, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0);
        #3 chk("eq_ctx1", int'(condex_o), 0);
        chk("flags_ctx1", int'(flags_o), 0);
        tick();

`ifdef COND_BLOCK_EN
        // NE block of 3 with Z=1: every instruction suppressed.
        drive(1, 4'b0001, 0, 4'h0, 2'b00, 1, 1, 1, 1, 4'd3);
        #3 chk("prefix_condex", int'(condex_o), 0);
        chk("prefix_reg_wr", int'(reg_wr_o), 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'b1110, 0, 4'h0, 2'b00, 1, 1, 1, 0, 4'h0);
            #3 chk("blk3_left", int'(blk_left_o), 3 - k);
            chk("blk3_reg_wr", int'(reg_wr_o), 0);
            chk("blk3_pc_src", int'(pc_src_o), 0);
            tick();
        end
        drive(0, 4'h0, 0, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0);
        #3 chk("blk3_closed", int'(blk_active_o), 0);
        tick();

        // Length clamp and reset mid-block.
        drive(1, 4'b1110, 0, 4'h0, 2'b00, 0, 0, 0, 1, 4'd9);
        tick();
        drive(1, 4'b1110, 0, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0);
        #3 chk("blk9_clamp", int'(blk_left_o), 4);
        tick();
        tick();
        rst = 1'b1;
        drive(1, 4'b1110, 0, 4'hF, 2'b11, 0, 0, 0, 1, 4'd5);
        tick();
        rst = 1'b0;
        drive(0, 4'h0, 0, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0);
        #3 chk("rst_mid_active", int'(blk_active_o), 0);
        chk("rst_mid_left", int'(blk_left_o), 0);
        chk("rst_mid_flags", int'(flags_o), 0);
        tick();

        // EQ block: first instruction clears Z, second must fail.
        drive(1, 4'b1110, 0, 4'b0100, 2'b10, 0, 0, 0, 0, 4'h0);
        tick();
        drive(1, 4'b0000, 0, 4'h0, 2'b00, 0, 0, 0, 1, 4'd2);
        tick();
        drive(1, 4'b1110, 0, 4'b0000, 2'b10, 1, 0, 0, 0, 4'h0);
        #3 chk("blkeq_first", int'(condex_o), 1);
        tick();
        drive(1, 4'b1110, 0, 4'h0, 2'b00, 1, 0, 0, 0, 4'h0);
        #3 chk("blkeq_second", int'(condex_o), 0);
        tick();
`else
        // Block request ignored: instruction evaluated normally.
        drive(1, 4'b1110, 0, 4'h0, 2'b00, 1, 0, 0, 1, 4'd5);
        #3 chk("noblk_reg_wr", int'(reg_wr_o), 1);
        chk("noblk_active", int'(blk_active_o), 0);
        tick();
        drive(1, 4'b1110, 0, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0);
        #3 chk("noblk_left", int'(blk_left_o), 0);
        tick();
`endif

        // Randomized traffic, checked every cycle by the compare process.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)),
                  int'($urandom_range(0, NUM_CTX - 1)),
                  4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0),
                  4'($urandom_range(0, 15)));
            tick();
        end
        rst = 1'b0;
        drive(0, 4'h0, 0, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0);
        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cond_exec_unit
`default_nettype wire
